// File: rtl/painterengine_gpu_dma_reader.sv
`timescale 1ns/1ps
// DMA reader: one (address, length) request becomes one AXI4 INCR read burst streamed straight to the client.
// Latency: arvalid two cycles after enable; R-to-client is combinational. Backpressure: rready follows data_next.
// Optional GPU_DMA_READER_4K_CHECK_EN rejects misaligned or 4 KB-crossing requests before any AR is issued.
module painterengine_gpu_dma_reader #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_resetn,
    input  logic [ADDR_WIDTH-1:0] i_wire_reader_address,
    input  logic [31:0]           i_wire_reader_length,
    input  logic                  i_wire_reader_resetn,
    output logic                  o_wire_reader_done,
    output logic                  o_wire_reader_error,
    output logic [31:0]           o_wire_reader_data,
    output logic                  o_wire_reader_data_valid,
    input  logic                  i_wire_reader_data_next,
    output logic [ADDR_WIDTH-1:0] o_wire_m_araddr,
    output logic [7:0]            o_wire_m_arlen,
    output logic [2:0]            o_wire_m_arsize,
    output logic [1:0]            o_wire_m_arburst,
    output logic                  o_wire_m_arvalid,
    input  logic                  i_wire_m_arready,
    input  logic [31:0]           i_wire_m_rdata,
    input  logic [1:0]            i_wire_m_rresp,
    input  logic                  i_wire_m_rlast,
    input  logic                  i_wire_m_rvalid,
    output logic                  o_wire_m_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ADDR, S_DATA, S_DONE, S_ERROR, S_DRAIN
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] ar_addr_nxt;
    logic [31:0]           len_q;
    logic [8:0]            beat_cnt;
    logic                  err_q;
    logic                  req_bad;
    logic                  beat;
    logic                  last_exp;
    logic                  final_beat;
    logic                  burst_bad;
    logic                  en;

    assign en               = i_wire_reader_resetn;
    assign o_wire_m_arsize  = 3'b010;
    assign o_wire_m_arburst = 2'b01;
    assign o_wire_reader_data = i_wire_m_rdata;

`ifdef GPU_DMA_READER_4K_CHECK_EN
    logic [12:0] span_end;

    assign ar_addr_nxt = addr_q;

    always_comb begin
        span_end = {1'b0, addr_q[11:0]} + {len_q[10:0], 2'b00} - 13'd1;
        req_bad  = (len_q == 32'd0) || (len_q > 32'(MAX_BURST_LEN));
        if (addr_q[1:0] != 2'b00 || span_end[12])
            req_bad = 1'b1;
    end
`else
    // Without the check the burst is simply word-aligned; 4 KB compliance is left to the client.
    assign ar_addr_nxt = addr_q & ~ADDR_WIDTH'(3);

    always_comb begin
        req_bad = (len_q == 32'd0) || (len_q > 32'(MAX_BURST_LEN));
    end
`endif

    assign beat       = i_wire_m_rvalid & o_wire_m_rready;
    assign last_exp   = (beat_cnt == {1'b0, o_wire_m_arlen});
    assign final_beat = i_wire_m_rlast | last_exp;
    assign burst_bad  = err_q | (i_wire_m_rresp != 2'b00) | (i_wire_m_rlast != last_exp);

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (en)
                    state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!en)
                    state_nxt = S_IDLE;
                else if (req_bad)
                    state_nxt = S_ERROR;
                else
                    state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (!en)
                    state_nxt = S_DRAIN;
                else if (o_wire_m_arvalid && i_wire_m_arready)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                // An abort coinciding with the last beat has already consumed the whole burst.
                if (!en)
                    state_nxt = (i_wire_m_rvalid && i_wire_m_rlast) ? S_IDLE : S_DRAIN;
                else if (beat && final_beat)
                    state_nxt = burst_bad ? S_ERROR : S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (!en)
                    state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (!o_wire_m_arvalid && i_wire_m_rvalid && i_wire_m_rlast)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_wire_m_rready          = 1'b0;
        o_wire_reader_data_valid = 1'b0;
        o_wire_reader_done       = 1'b0;
        o_wire_reader_error      = 1'b0;
        case (state)
            S_DATA: begin
                o_wire_m_rready          = en ? (err_q | i_wire_reader_data_next) : 1'b1;
                o_wire_reader_data_valid = en & ~err_q & i_wire_m_rvalid & i_wire_reader_data_next
                                         & (i_wire_m_rresp == 2'b00);
            end
            S_DRAIN: o_wire_m_rready     = 1'b1;
            S_DONE:  o_wire_reader_done  = 1'b1;
            S_ERROR: o_wire_reader_error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            addr_q           <= '0;
            len_q            <= '0;
            o_wire_m_araddr  <= '0;
            o_wire_m_arlen   <= '0;
            o_wire_m_arvalid <= 1'b0;
            beat_cnt         <= '0;
            err_q            <= 1'b0;
        end else begin
            // AR stays up through an abort until the interconnect takes it.
            if (o_wire_m_arvalid && i_wire_m_arready)
                o_wire_m_arvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        addr_q <= i_wire_reader_address;
                        len_q  <= i_wire_reader_length;
                    end
                end
                S_CHECK: begin
                    err_q <= 1'b0;
                    if (en && !req_bad) begin
                        o_wire_m_arvalid <= 1'b1;
                        o_wire_m_araddr  <= ar_addr_nxt;
                        o_wire_m_arlen   <= 8'(len_q - 32'd1);
                    end
                end
                S_ADDR: begin
                    if (o_wire_m_arvalid && i_wire_m_arready)
                        beat_cnt <= '0;
                end
                S_DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (i_wire_m_rresp != 2'b00)
                            err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
`timescale 1ns/1ps
// Scoreboarded bench: AXI slave model plus client, expected AR/words queued per request and checked by a monitor.
module tb_painterengine_gpu_dma_reader;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_len  = '0;
    logic        en       = 1'b0;
    logic        done, error, dvalid;
    logic [31:0] ddata;
    logic        dn = 1'b0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata   = '0;
    logic [1:0]  rresp   = '0;
    logic        rlast   = 1'b0;
    logic        rvalid  = 1'b0;
    logic        rready;

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader dut (
        .i_wire_clock             (clk),
        .i_wire_resetn            (rstn),
        .i_wire_reader_address    (req_addr),
        .i_wire_reader_length     (req_len),
        .i_wire_reader_resetn     (en),
        .o_wire_reader_done       (done),
        .o_wire_reader_error      (error),
        .o_wire_reader_data       (ddata),
        .o_wire_reader_data_valid (dvalid),
        .i_wire_reader_data_next  (dn),
        .o_wire_m_araddr          (araddr),
        .o_wire_m_arlen           (arlen),
        .o_wire_m_arsize          (arsize),
        .o_wire_m_arburst         (arburst),
        .o_wire_m_arvalid         (arvalid),
        .i_wire_m_arready         (arready),
        .i_wire_m_rdata           (rdata),
        .i_wire_m_rresp           (rresp),
        .i_wire_m_rlast           (rlast),
        .i_wire_m_rvalid          (rvalid),
        .o_wire_m_rready          (rready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [39:0] exp_ar[$];
    logic [31:0] exp_data[$];
    logic [31:0] b_addr[$];
    int          b_len[$];
    int          s_err_beat  = -1;
    int          s_ar_delay  = 0;
    int          dn_mode     = 0;
    int          rv_pct      = 100;
    bit          mirror_chk  = 1'b0;
    bit          ar_hs       = 1'b0;
    bit          r_hs        = 1'b0;
    int          beat_idx    = 0;
    int          ar_wait     = 0;
    int          last_hs_cyc = -10;
    logic [31:0] cap_addr;
    logic [7:0]  cap_len;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_ok(input logic [31:0] a, input int len);
        bit ok;
        ok = (len >= 1) && (len <= 256);
`ifdef GPU_DMA_READER_4K_CHECK_EN
        if (a[1:0] != 2'b00 || (int'(a % 32'd4096) + 4 * len > 4096))
            ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AXI slave and client data_next driver; handshakes are resolved mid-cycle and applied next cycle.
    initial begin : driver
        forever begin
            @(negedge clk);
            if (!rstn) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0; dn = 1'b0;
                ar_hs = 1'b0; r_hs = 1'b0; beat_idx = 0; ar_wait = 0;
            end else begin
                if (ar_hs) begin
                    b_addr.push_back(cap_addr);
                    b_len.push_back(int'(cap_len) + 1);
                end
                if (r_hs) begin
                    rvalid = 1'b0;
                    beat_idx++;
                    if (beat_idx >= b_len[0]) begin
                        void'(b_addr.pop_front());
                        void'(b_len.pop_front());
                        beat_idx = 0;
                    end
                end
                ar_wait = arvalid ? ar_wait + 1 : 0;
                arready = arvalid && (ar_wait > s_ar_delay);
                if (!rvalid && b_len.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
                    rdata  = mem_word(b_addr[0] + 32'(4 * beat_idx));
                    rresp  = (beat_idx == s_err_beat) ? 2'b10 : 2'b00;
                    rlast  = (beat_idx == b_len[0] - 1);
                    rvalid = 1'b1;
                end
                case (dn_mode)
                    0:       dn = 1'b1;
                    1:       dn = ~dn;
                    default: dn = 1'($urandom_range(1));
                endcase
                #1;
                ar_hs    = arvalid && arready;
                cap_addr = araddr;
                cap_len  = arlen;
                r_hs     = rvalid && rready;
                if (r_hs && rlast)
                    last_hs_cyc = cyc;
            end
        end
    end

    initial begin : monitor
        logic [39:0] e_ar;
        logic [31:0] e_d;
        forever begin
            @(negedge clk);
            #2;
            if (rstn) begin
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_ar: got addr %0h len %0d expected no AR", araddr, arlen);
                    end else begin
                        e_ar = exp_ar.pop_front();
                        check("ar_addr", 64'(araddr), 64'(e_ar[39:8]));
                        check("ar_len",  64'(arlen),  64'(e_ar[7:0]));
                    end
                end
                if (dvalid) begin
                    if (exp_data.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_word: got %0h expected no word", ddata);
                    end else begin
                        e_d = exp_data.pop_front();
                        check("word", 64'(ddata), 64'(e_d));
                    end
                end
                if (mirror_chk && rvalid)
                    check("rready_mirror", 64'(rready), 64'(dn));
            end
        end
    end

    task automatic run_req(input logic [31:0] a, input int len, input int errb, input int mode, input int ardly);
        bit valid, exp_err;
        int nw, t;
        valid = model_ok(a, len);
        s_err_beat = errb;
        dn_mode    = mode;
        s_ar_delay = ardly;
        if (valid) begin
            exp_ar.push_back({a & ~32'h3, 8'(len - 1)});
            exp_err = (errb >= 0) && (errb < len);
            nw = exp_err ? errb : len;
            for (int i = 0; i < nw; i++)
                exp_data.push_back(mem_word((a & ~32'h3) + 32'(4 * i)));
        end else begin
            exp_err = 1'b1;
        end
        @(negedge clk);
        req_addr   = a;
        req_len    = 32'(len);
        en         = 1'b1;
        mirror_chk = (mode == 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        if (valid) begin
            check("arvalid_at_n2", 64'(arvalid), 64'(1));
        end else begin
            check("error_at_n2", 64'(error), 64'(1));
            check("no_arvalid", 64'(arvalid), 64'(0));
        end
        t = 0;
        while (!(done || error) && t < 4000) begin
            @(negedge clk);
            #3;
            t++;
        end
        if (t >= 4000) begin
            n_tests++; n_fail++;
            $display("FAIL completion_timeout: got no done/error expected one within 4000 cycles");
        end else begin
            check("done",  64'(done),  64'(!exp_err));
            check("error", 64'(error), 64'(exp_err));
            if (valid)
                check("flag_latency", 64'(cyc), 64'(last_hs_cyc + 1));
        end
        check("words_left", 64'(exp_data.size()), 64'(0));
        check("ar_left",    64'(exp_ar.size()),   64'(0));
        mirror_chk = 1'b0;
        exp_data.delete();
        exp_ar.delete();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("flags_clear", 64'({done, error}), 64'(0));
        t = 0;
        while (b_len.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_abort(input logic [31:0] a, input int len);
        int t;
        s_err_beat = -1;
        dn_mode    = 0;
        s_ar_delay = 12;
        exp_ar.push_back({a & ~32'h3, 8'(len - 1)});
        @(negedge clk);
        req_addr = a;
        req_len  = 32'(len);
        en       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_arvalid_up", 64'(arvalid), 64'(1));
        @(negedge clk);
        en = 1'b0;
        t = 0;
        while (!(arvalid && arready) && t < 100) begin
            @(negedge clk);
            #3;
            if (!arready)
                check("arvalid_held", 64'(arvalid), 64'(1));
            t++;
        end
        check("abort_ar_handshake", 64'(arvalid && arready), 64'(1));
        @(negedge clk);
        #3;
        t = 0;
        while ((b_len.size() > 0 || rvalid) && t < 2000) begin
            @(negedge clk);
            #3;
            check("drain_flags", 64'({done, error}), 64'(0));
            t++;
        end
        check("drain_finished", 64'(b_len.size()), 64'(0));
        check("abort_ar_left", 64'(exp_ar.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        logic [31:0] a;
        int len, eb, mode_sel;
        #1;
        check("rst_done",    64'(done),    64'(0));
        check("rst_error",   64'(error),   64'(0));
        check("rst_dvalid",  64'(dvalid),  64'(0));
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_rready",  64'(rready),  64'(0));
        check("rst_araddr",  64'(araddr),  64'(0));
        check("rst_arlen",   64'(arlen),   64'(0));
        check("rst_arsize",  64'(arsize),  64'(3'b010));
        check("rst_arburst", 64'(arburst), 64'(2'b01));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        rv_pct = 100;
        run_req(32'h1000_0200, 128, -1, 0, 3);
        run_req(32'h1000_0200, 128, -1, 1, 0);
        run_req(32'h2000_0000, 0,   -1, 0, 0);
        run_req(32'h2000_0000, 257, -1, 0, 0);
        run_req(32'h3000_0100, 16,  5,  0, 1);
        run_abort(32'h4000_0400, 32);
        run_req(32'h4000_0800, 8,   -1, 0, 0);
        run_req(32'h1000_0FF0, 8,   -1, 0, 0);
        run_req(32'h5000_0000, 1,   -1, 2, 2);
        run_req(32'h6000_0000, 256, -1, 2, 0);

        for (int k = 0; k < 16; k++) begin
            mode_sel = int'($urandom_range(7));
            if (mode_sel == 0)
                len = 0;
            else if (mode_sel == 1)
                len = 257 + int'($urandom_range(100));
            else
                len = 1 + int'($urandom_range(47));
            a = $urandom;
            if ($urandom_range(3) != 0)
                a[1:0] = 2'b00;
            eb = ($urandom_range(3) == 0) ? int'($urandom_range(47)) : -1;
            rv_pct = 40 + int'($urandom_range(60));
            run_req(a, len, eb, 2, int'($urandom_range(4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/painterengine_gpu_dma_reader.md
# painterengine_gpu_dma_reader

DMA read engine serving the display pipeline's reader request port: accepts one (address, length) request per enable cycle of `i_wire_reader_resetn`. It fetches the words as a single AXI4 INCR read burst and streams them to the client under the client's `data_next` flow control. It reports completion or failure with sticky `done`/`error` flags. It sits between the display block and the system memory interconnect.

## Interface
- ADDR_WIDTH, 32, byte address width.
- MAX_BURST_LEN, 256, maximum words per request (1..256).
- i_wire_clock  in  1  system clock.
- i_wire_resetn  in  1  reset, asynchronous, active-low.
- i_wire_reader_address  in  32  start byte address.
- i_wire_reader_length  in  32  length in 32-bit words.
- i_wire_reader_resetn  in  1  request enable: low = idle/abort, rising = start.
- o_wire_reader_done  out  1  request completed OK; sticky.
- o_wire_reader_error  out  1  request failed; sticky.
- o_wire_reader_data  out  32  streamed word.
- o_wire_reader_data_valid  out  1  word valid this cycle.
- i_wire_reader_data_next  in  1  client can accept a word this cycle.
- o_wire_m_araddr  out  32 / o_wire_m_arlen  out  8 / o_wire_m_arsize  out  3 (fixed 3'b010) / o_wire_m_arburst  out  2 (fixed 2'b01) / o_wire_m_arvalid  out  1 / i_wire_m_arready  in  1: AXI4 AR channel.
- i_wire_m_rdata  in  32 / i_wire_m_rresp  in  2 / i_wire_m_rlast  in  1 / i_wire_m_rvalid  in  1 / o_wire_m_rready  out  1: AXI4 R channel.

## Operation
- States: IDLE, CHECK, ADDR, DATA, DONE, ERROR, DRAIN.
- IDLE: when `i_wire_reader_resetn`=1, latch address and length, then go to CHECK.
- CHECK: if length==0 or length>MAX_BURST_LEN, go to ERROR. Otherwise set araddr=address, arlen=length-1, arvalid=1, and go to ADDR.
- ADDR: hold arvalid and araddr/arlen stable until arready. On the handshake, deassert arvalid and go to DATA. Clear the 9-bit beat counter.
- DATA: rready = data_next. data = rdata (combinational). data_valid = rvalid & rready & (rresp==OKAY). Increment the counter on each accepted beat.
  - rresp!=OKAY on a beat: the beat is not forwarded and an error is latched. Remaining beats are consumed with rready=1.
  - rlast on the beat where counter != arlen, or no rlast when counter==arlen: latch an error.
  - On the final accepted beat, go to DONE, or to ERROR if an error is latched.
- DONE/ERROR: hold the flag at 1 with rready=0 until `i_wire_reader_resetn`=0, then go to IDLE.
- Abort: if `i_wire_reader_resetn` drops in ADDR or DATA, go to DRAIN.
  - DRAIN keeps arvalid asserted until arready if the AR handshake is still pending (AXI rule).
  - It then accepts beats with rready=1 and data_valid=0 until rlast, then goes to IDLE.
  - A new request is not sampled before IDLE.
- Abort in CHECK returns to IDLE with no AR issued.

## Timing
- Reset values: all outputs 0, arsize=3'b010, arburst=2'b01, state IDLE.
- Enable high at cycle N: CHECK at N+1, arvalid=1 at N+2.
- Data path has zero latency from R to client. rready is combinational from data_next; no word is buffered internally.
- done/error rise the cycle after the last beat handshake. Both are 0 whenever the state is not DONE/ERROR.
- Re-entering IDLE takes 1 cycle after enable falls from DONE/ERROR. A client that re-raises enable on the next cycle starts a new request.
- Asynchronous reset mid-burst forces IDLE immediately. The system must reset the interconnect concurrently.
- Simultaneous rvalid and abort in the same cycle: that beat is handled by DRAIN rules and is not forwarded.

## Configuration
- `GPU_DMA_READER_4K_CHECK_EN` defined: CHECK also sends a request to ERROR when the address is not 4-byte aligned, or when address + 4*length - 1 crosses a 4 KB boundary. No AR is issued in that case.
- Undefined: these checks are absent. araddr[1:0] is forced to 0, and boundary compliance is the client's responsibility.

## Test plan
- Address 0x1000_0200, length 128, slave arready after 3 cycles, data_next always 1 -> arlen=127, 128 words forwarded in order, done=1 one cycle after the rlast beat, error=0.
- Same request with data_next toggling 1/0 every cycle -> rready mirrors data_next, exactly 128 data_valid pulses, no word lost or duplicated.
- Length 0, then length 257 -> error=1 at cycle N+2, arvalid never asserted.
- Slave returns SLVERR on beat 5 of 16 -> 5 words forwarded, remaining 11 consumed with data_valid=0, error=1 after rlast, done=0.
- Enable dropped while arvalid=1 and arready=0 -> arvalid held until arready, all 32 beats drained with data_valid=0, then IDLE. A following request for 8 words completes with done=1.
- Macro defined, address 0x1000_0FF0, length 8 -> error=1 with no AR issued. Macro undefined -> burst issued and done=1.
